// File: rtl/alu_issue_pkg.sv
// Shared types for the execute-stage issue unit: ALU operation encoding, data word,
// RV32I opcodes handled here, and the decoded issue entry.
package alu_issue_pkg;

   typedef logic [31:0] Data;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_SLL  = 3'd2,
      ALU_SLT  = 3'd3,
      ALU_SLTU = 3'd4,
      ALU_XOR  = 3'd5,
      ALU_OR   = 3'd6,
      ALU_AND  = 3'd7
   } AluOp;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

   typedef struct packed {
      AluOp op;
      Data  a;
      Data  b;
      logic illegal;
      Data  pc;
   } IssueEntry;

   localparam IssueEntry ENTRY_RESET = '{op: ALU_ADD, a: '0, b: '0, illegal: 1'b0, pc: '0};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } BufState;

   // Reference behaviour of the combinational ALU that sits behind this stage.
   function automatic Data alu_eval(AluOp op, Data a, Data b);
      Data r;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: r = {31'b0, a < b};
         ALU_XOR:  r = a ^ b;
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of RV32I OP / OP-IMM / LUI / AUIPC into an ALU issue entry;
// anything else is flagged illegal with a neutral ADD 0,0 payload.
module alu_decode
   import alu_issue_pkg::*;
(
   input  logic [31:0] i_inst,
   input  Data         i_pc,
   input  Data         i_rs1,
   input  Data         i_rs2,
   output IssueEntry   o_entry
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   Data        w_imm_i;
   Data        w_imm_u;
   AluOp       w_op;
   Data        w_a;
   Data        w_b;
   logic       w_bad;
   logic       w_unused_rd;

   assign w_opcode    = i_inst[6:0];
   assign w_funct3    = i_inst[14:12];
   assign w_funct7    = i_inst[31:25];
   assign w_imm_i     = {{20{i_inst[31]}}, i_inst[31:20]};
   assign w_imm_u     = {i_inst[31:12], 12'b0};
   assign w_unused_rd = ^i_inst[11:7];

   always_comb begin
      w_op  = ALU_ADD;
      w_a   = '0;
      w_b   = '0;
      w_bad = 1'b0;
      case (w_opcode)
         OPCODE_OP: begin
            w_a = i_rs1;
            w_b = i_rs2;
            case (w_funct3)
               3'b000: begin
                  if (w_funct7 == 7'b0100000) w_op = ALU_SUB;
                  else if (w_funct7 != 7'b0000000) w_bad = 1'b1;
               end
               3'b001:  w_op = ALU_SLL;
               3'b010:  w_op = ALU_SLT;
               3'b011:  w_op = ALU_SLTU;
               3'b100:  w_op = ALU_XOR;
               3'b110:  w_op = ALU_OR;
               3'b111:  w_op = ALU_AND;
               default: w_bad = 1'b1;
            endcase
            if (w_funct3 != 3'b000 && w_funct7 != 7'b0000000) w_bad = 1'b1;
         end
         OPCODE_OP_IMM: begin
            w_a = i_rs1;
            w_b = w_imm_i;
            case (w_funct3)
               3'b000: w_op = ALU_ADD;
               3'b001: begin
                  w_op = ALU_SLL;
                  w_b  = {27'b0, i_inst[24:20]};
                  if (w_funct7 != 7'b0000000) w_bad = 1'b1;
               end
               3'b010:  w_op = ALU_SLT;
               3'b011:  w_op = ALU_SLTU;
               3'b100:  w_op = ALU_XOR;
               3'b110:  w_op = ALU_OR;
               3'b111:  w_op = ALU_AND;
               default: w_bad = 1'b1;
            endcase
         end
         OPCODE_LUI: begin
            w_a = '0;
            w_b = w_imm_u;
         end
         OPCODE_AUIPC: begin
            w_a = i_pc;
            w_b = w_imm_u;
         end
         default: w_bad = 1'b1;
      endcase
   end

   // Illegal entries still travel down the pipe so the trap is taken in order.
   always_comb begin
      o_entry         = ENTRY_RESET;
      o_entry.pc      = i_pc;
      o_entry.illegal = w_bad;
      if (!w_bad) begin
         o_entry.op = w_op;
         o_entry.a  = w_a;
         o_entry.b  = w_b;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: decodes on the input side and buffers decoded
// entries in a two-entry skid buffer (HAS_SKID=1) or a single pipeline register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no entry held, o_valid low
// ST_ONE   | oldest entry in r_head, r_tail free
// ST_TWO   | r_head oldest, r_tail next; input blocked (skid mode only)
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter bit HAS_SKID = 1'b1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_rs1Data,
   input  logic [31:0] i_rs2Data,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output AluOp        o_op,
   output logic [31:0] o_operandA,
   output logic [31:0] o_operandB,
   output logic        o_illegal,
   output logic [31:0] o_pc
);

   IssueEntry w_dec;
   IssueEntry r_head;
   IssueEntry r_tail;
   BufState   r_state;
   BufState   w_state_nxt;
   logic      w_in;
   logic      w_out;
   logic      w_load_head;
   logic      w_head_from_tail;
   logic      w_load_tail;

   alu_decode u_decode (
      .i_inst  (i_inst),
      .i_pc    (i_pc),
      .i_rs1   (i_rs1Data),
      .i_rs2   (i_rs2Data),
      .o_entry (w_dec)
   );

   assign o_valid = (r_state != ST_EMPTY);
   assign w_in    = i_valid && o_ready;
   assign w_out   = o_valid && i_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_head      = 1'b0;
      w_head_from_tail = 1'b0;
      w_load_tail      = 1'b0;
      if (i_flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in) begin
                  w_state_nxt = ST_ONE;
                  w_load_head = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_in && w_out) begin
                  w_load_head = 1'b1;
               end else if (w_in) begin
                  w_state_nxt = ST_TWO;
                  w_load_tail = 1'b1;
               end else if (w_out) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_out) begin
                  w_state_nxt      = ST_ONE;
                  w_head_from_tail = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_EMPTY;
         r_head  <= ENTRY_RESET;
         r_tail  <= ENTRY_RESET;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_head)           r_head <= w_dec;
         else if (w_head_from_tail) r_head <= r_tail;
         if (w_load_tail)           r_tail <= w_dec;
      end
   end

   // Skid mode registers o_ready so i_ready never reaches it combinationally.
   generate
      if (HAS_SKID) begin : g_skid
         logic r_ready;
         always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) r_ready <= 1'b1;
            else          r_ready <= (w_state_nxt != ST_TWO);
         end
         assign o_ready = r_ready;
      end else begin : g_single
         assign o_ready = !o_valid || i_ready;
      end
   endgenerate

   assign o_op       = r_head.op;
   assign o_operandA = r_head.a;
   assign o_operandB = r_head.b;
   assign o_illegal  = r_head.illegal;
   assign o_pc       = r_head.pc;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, skid fill/drain, flush, async reset,
// plus a HAS_SKID=0 instance sharing the same stimulus for the combinational-ready mode.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_valid = 1'b0;
   logic [31:0] i_inst = '0;
   logic [31:0] i_pc = '0;
   logic [31:0] i_rs1Data = '0;
   logic [31:0] i_rs2Data = '0;
   logic        i_flush = 1'b0;
   logic        i_ready = 1'b0;

   logic        o_ready, o_valid, o_illegal;
   AluOp        o_op;
   logic [31:0] o_operandA, o_operandB, o_pc;

   logic        s_ready, s_valid, s_illegal;
   AluOp        s_op;
   logic [31:0] s_operandA, s_operandB, s_pc;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 i_clock = ~i_clock;

   alu_issue #(.HAS_SKID(1'b1)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_inst(i_inst), .i_pc(i_pc), .i_rs1Data(i_rs1Data), .i_rs2Data(i_rs2Data),
      .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op),
      .o_operandA(o_operandA), .o_operandB(o_operandB), .o_illegal(o_illegal), .o_pc(o_pc)
   );

   alu_issue #(.HAS_SKID(1'b0)) dut_single (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(s_ready),
      .i_inst(i_inst), .i_pc(i_pc), .i_rs1Data(i_rs1Data), .i_rs2Data(i_rs2Data),
      .i_flush(i_flush), .o_valid(s_valid), .i_ready(i_ready), .o_op(s_op),
      .o_operandA(s_operandA), .o_operandB(s_operandB), .o_illegal(s_illegal), .o_pc(s_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      i_valid   = v;
      i_inst    = inst;
      i_pc      = pc;
      i_rs1Data = rs1;
      i_rs2Data = rs2;
   endtask

   task automatic issue_check(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input AluOp eop, input logic [31:0] ea, input logic [31:0] eb,
                              input logic eill);
      drive(1'b1, inst, pc, rs1, rs2);
      i_ready = 1'b1;
      tick();
      chk({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
      chk({tag, "_op"}, {29'b0, o_op}, {29'b0, eop});
      chk({tag, "_a"}, o_operandA, ea);
      chk({tag, "_b"}, o_operandB, eb);
      chk({tag, "_ill"}, {31'b0, o_illegal}, {31'b0, eill});
      chk({tag, "_pc"}, o_pc, pc);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
      chk({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
      chk({tag, "_op"}, {29'b0, o_op}, {29'b0, ALU_ADD});
      chk({tag, "_a"}, o_operandA, 32'd0);
      chk({tag, "_b"}, o_operandB, 32'd0);
      chk({tag, "_ill"}, {31'b0, o_illegal}, 32'd0);
      chk({tag, "_pc"}, o_pc, 32'd0);
   endtask

   initial begin
      #12;
      chk_reset_outputs("rst");
      @(negedge i_clock);
      i_reset = 1'b1;

      // Decode vectors, i_ready held high
      issue_check("add", 32'h002081B3, 32'h40, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'd7, 1'b0);
      chk("add_alu", alu_eval(o_op, o_operandA, o_operandB), 32'd12);
      issue_check("addi", 32'hFFF00093, 32'h44, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'hFFFFFFFF, 1'b0);
      issue_check("slli", 32'h01F09093, 32'h48, 32'd1, 32'd9, ALU_SLL, 32'd1, 32'd31, 1'b0);
      chk("slli_alu", alu_eval(o_op, o_operandA, o_operandB), 32'h80000000);
      issue_check("auipc", 32'h12345297, 32'h100, 32'd3, 32'd4, ALU_ADD, 32'h100, 32'h12345000, 1'b0);
      issue_check("srl", 32'h0020D1B3, 32'h104, 32'd8, 32'd2, ALU_ADD, 32'd0, 32'd0, 1'b1);
      issue_check("lui", 32'h123452B7, 32'h108, 32'd6, 32'd6, ALU_ADD, 32'd0, 32'h12345000, 1'b0);
      issue_check("sub", 32'h402081B3, 32'h10C, 32'd9, 32'd4, ALU_SUB, 32'd9, 32'd4, 1'b0);
      issue_check("sltu", 32'h0020B1B3, 32'h110, 32'd1, 32'd2, ALU_SLTU, 32'd1, 32'd2, 1'b0);
      issue_check("xor_f7", 32'h4020C1B3, 32'h114, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 1'b1);
      issue_check("slli_f7", 32'h41F09093, 32'h118, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 1'b1);
      issue_check("load", 32'h0000A083, 32'h11C, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 1'b1);
      issue_check("andi", 32'h0FF0F093, 32'h120, 32'h1234, 32'd0, ALU_AND, 32'h1234, 32'hFF, 1'b0);

      drive(1'b0, '0, '0, '0, '0);
      tick();
      chk("drain_valid", {31'b0, o_valid}, 32'd0);

      // Skid: I0, I1, I2 back to back, stall from second cycle
      drive(1'b1, 32'h00100093, 32'h200, 32'd0, 32'd0);
      i_ready = 1'b1;
      tick();
      chk("sk_i0_pc", o_pc, 32'h200);
      chk("sk_i0_rdy", {31'b0, o_ready}, 32'd1);
      drive(1'b1, 32'h00200093, 32'h204, 32'd0, 32'd0);
      i_ready = 1'b0;
      tick();
      chk("sk_two_pc", o_pc, 32'h200);
      chk("sk_two_rdy", {31'b0, o_ready}, 32'd0);
      drive(1'b1, 32'h00300093, 32'h208, 32'd0, 32'd0);
      tick();
      chk("sk_hold_pc", o_pc, 32'h200);
      chk("sk_hold_b", o_operandB, 32'd1);
      chk("sk_hold_rdy", {31'b0, o_ready}, 32'd0);
      chk("sk_hold_valid", {31'b0, o_valid}, 32'd1);
      i_ready = 1'b1;
      tick();
      chk("sk_i1_pc", o_pc, 32'h204);
      chk("sk_i1_b", o_operandB, 32'd2);
      chk("sk_i1_rdy", {31'b0, o_ready}, 32'd1);
      tick();
      chk("sk_i2_pc", o_pc, 32'h208);
      chk("sk_i2_b", o_operandB, 32'd3);
      drive(1'b0, '0, '0, '0, '0);
      tick();
      chk("sk_end_valid", {31'b0, o_valid}, 32'd0);

      // Flush while TWO with a new instruction offered
      i_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h300, 32'd0, 32'd0);
      tick();
      drive(1'b1, 32'h00200093, 32'h304, 32'd0, 32'd0);
      tick();
      chk("fl_two_rdy", {31'b0, o_ready}, 32'd0);
      drive(1'b1, 32'h00300093, 32'h308, 32'd0, 32'd0);
      i_flush = 1'b1;
      tick();
      chk("fl_valid", {31'b0, o_valid}, 32'd0);
      chk("fl_rdy", {31'b0, o_ready}, 32'd1);
      i_flush = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      i_ready = 1'b1;
      tick();
      chk("fl_after_valid", {31'b0, o_valid}, 32'd0);

      // Flush while ONE with an input that would otherwise be accepted
      i_ready = 1'b0;
      drive(1'b1, 32'h00100093, 32'h400, 32'd0, 32'd0);
      tick();
      drive(1'b1, 32'h00500093, 32'h404, 32'd0, 32'd0);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      chk("fl1_valid", {31'b0, o_valid}, 32'd0);
      tick();
      chk("fl1_after_valid", {31'b0, o_valid}, 32'd0);

      // Async reset in state ONE, checked before the next edge
      drive(1'b1, 32'h00700093, 32'h500, 32'd0, 32'd0);
      i_ready = 1'b0;
      tick();
      drive(1'b0, '0, '0, '0, '0);
      chk("ar_pre_valid", {31'b0, o_valid}, 32'd1);
      #2;
      i_reset = 1'b0;
      #1;
      chk_reset_outputs("ar");
      @(negedge i_clock);
      i_reset = 1'b1;

      // Single-register mode: combinational ready
      #1;
      chk("sg_empty_rdy", {31'b0, s_ready}, 32'd1);
      drive(1'b1, 32'h00100093, 32'h600, 32'd0, 32'd0);
      tick();
      chk("sg_valid", {31'b0, s_valid}, 32'd1);
      chk("sg_pc0", s_pc, 32'h600);
      chk("sg_stall_rdy", {31'b0, s_ready}, 32'd0);
      i_ready = 1'b1;
      #1;
      chk("sg_comb_rdy", {31'b0, s_ready}, 32'd1);
      drive(1'b1, 32'h00200093, 32'h604, 32'd0, 32'd0);
      tick();
      chk("sg_pc1", s_pc, 32'h604);
      chk("sg_b1", s_operandB, 32'd2);
      drive(1'b0, '0, '0, '0, '0);
      tick();
      chk("sg_end_valid", {31'b0, s_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue unit sitting in front of the ALU: accepts a register-read instruction with a valid/ready handshake and decodes RV32I OP, OP-IMM, LUI and AUIPC into `AluOp`, operand A and operand B. The result is registered into a small elastic buffer that drives the ALU's inputs. The ALU itself stays purely combinational behind this stage. Unsupported encodings are flagged rather than dropped, so the downstream stage can trap in program order.

## Interface
- `HAS_SKID`, default 1: 1 = two-entry skid buffer with registered `o_ready`; 0 = single register with combinational `o_ready`.
- `i_clock` in 1: sole clock, rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_valid` in 1: upstream instruction valid.
- `o_ready` out 1: stage can accept.
- `i_inst` in 32: instruction word.
- `i_pc` in 32: instruction address.
- `i_rs1Data` in 32: rs1 register value.
- `i_rs2Data` in 32: rs2 register value.
- `i_flush` in 1: synchronous pipeline flush.
- `o_valid` out 1: issue entry valid toward the ALU/EX.
- `i_ready` in 1: downstream accepts.
- `o_op` out `AluOp`: ALU operation.
- `o_operandA` out 32: ALU operand A.
- `o_operandB` out 32: ALU operand B.
- `o_illegal` out 1: entry is an unsupported encoding.
- `o_pc` out 32: PC carried with the entry.

## Operation
- **Transfers:**
  - An input transfer happens when `i_valid && o_ready`.
  - An output transfer happens when `o_valid && i_ready`.
  - Order is FIFO; `o_*` always shows the oldest entry.
- **OP (0110011)**, A = rs1, B = rs2:
  - funct3 000: funct7 0000000 → ADD; 0100000 → SUB.
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR; 110 → OR; 111 → AND.
  - For every funct3 except 000, funct7 must be 0000000.
- **OP-IMM (0010011)**, A = rs1, B = sign-extended `inst[31:20]`:
  - 000 → ADD; 010 → SLT; 011 → SLTU; 100 → XOR; 110 → OR; 111 → AND.
  - 001 → SLL with B = zero-extended `inst[24:20]`; requires `inst[31:25]` = 0.
- **LUI (0110111):** ADD, A = 0, B = {`inst[31:12]`, 12'b0}.
- **AUIPC (0010111):** ADD, A = `i_pc`, B = U-immediate.
- **Illegal:** funct3 101 (right shifts have no `AluOp`), a bad funct7, or any other opcode.
  - Entry is still accepted with `o_illegal`=1, `o_op`=ADD, A=B=0.
- **HAS_SKID=1 state machine**, states EMPTY / ONE / TWO:
  - EMPTY + in → ONE.
  - ONE + in + out → ONE; ONE + in, no out → TWO; ONE + out, no in → EMPTY.
  - TWO + out → ONE; no input is possible while in TWO.
  - `o_ready` is a register, equal to (next state ≠ TWO).
- **HAS_SKID=0:** single entry; `o_ready` = `!o_valid || i_ready`.
- **Flush:** `i_flush` has priority over all transfers.
  - Next state is EMPTY; an input offered in the flush cycle is discarded.
  - `o_ready`=1 the cycle after the flush.
- **Reset values:** `o_valid`=0, `o_ready`=1, `o_op`=ADD, `o_operandA`=`o_operandB`=0, `o_illegal`=0, `o_pc`=0, state EMPTY.
  - A reset in the middle of operation drops all entries immediately (asynchronous).

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on `o_*` with `o_valid`=1 after edge N.
- Throughput is 1 entry/cycle while `i_ready`=1, in both modes.
- `o_*` stays stable while `o_valid && !i_ready`; the ALU output is therefore stable as well.
- HAS_SKID=1: no combinational path from `i_ready` to `o_ready`.
  - Worst case, one extra entry is absorbed after the downstream stalls.
- Decode is combinational on the input side; the registers hold decoded fields, not raw instructions.

## Structure
- Shared `Types` package additions:
  - Opcode constants `OPCODE_OP`, `OPCODE_OP_IMM`, `OPCODE_LUI`, `OPCODE_AUIPC`.
  - Struct `IssueEntry` {`AluOp` op; `Data` a; `Data` b; logic illegal; `Data` pc}.
- `AluOp` and `Data` are reused unchanged.
- Sub-module `alu_decode` (combinational): inputs inst, pc, rs1, rs2 → output `IssueEntry`.
- The top level `alu_issue` holds the buffer registers and the state machine.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, i_ready=1 → next cycle op=ADD, A=5, B=7, illegal=0; ALU gives 12.
- `addi x1,x0,-1` (0xFFF00093), then `slli x1,x1,31` (0x01F09093) with rs1=1 → B=0xFFFFFFFF, then B=31 for the SLLI with op=SLL.
- `auipc x5,0x12345` (0x12345297), pc=0x100 → op=ADD, A=0x100, B=0x12345000; `srl` (0x0020D1B3) → illegal=1, A=B=0.
- HAS_SKID=1, back-to-back inputs I0, I1, I2 with i_ready held 0 from the second cycle:
  - State reaches TWO; o_ready falls one cycle later; I2 is held upstream.
  - Releasing i_ready drains I0, I1, I2 in order; no loss and no duplicate.
- i_flush in state TWO together with a new i_valid → next cycle o_valid=0, o_ready=1, and the offered instruction never appears.
- i_reset low mid-stream (state ONE, asynchronous edge) → o_valid=0 and all outputs at reset values before the next clock edge.
